syrup_channel_fifo: RTL and testbench

Buffered channel body joining a `SyrupOutChannel` producer to a `SyrupInChannel` consumer within one clock domain. It stores up to 2^ADDR_WIDTH words written through `syrup_d`/`syrup_we` and presents them in order on `syrup_q`, first-word-fall-through, popped by `syrup_re`. Full/empty status, occupancy and sticky overflow/underflow flags let the surrounding simulation framework detect channel misuse. One instance is generated per channel ID.

---
 rtl/syrup_channel_fifo.sv | 88 ++++++++
 tb/tb_syrup_channel_fifo.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/syrup_channel_fifo.sv
// First-word-fall-through channel FIFO joining one producer to one consumer in a single clock domain.
// Keeps sticky overflow/underflow flags so the host framework can detect channel misuse.
module syrup_channel_fifo #(
  parameter string DOMAIN     = "undefined",
  parameter int    ID         = 0,
  parameter int    DATA_WIDTH = 32,
  parameter int    ADDR_WIDTH = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] syrup_d,
  input  logic                  syrup_we,
  output logic [DATA_WIDTH-1:0] syrup_q,
  input  logic                  syrup_re,
  output logic                  FULL,
  output logic                  EMPTY,
  output logic [ADDR_WIDTH:0]   COUNT,
  output logic                  OVERFLOW,
  output logic                  UNDERFLOW,
  input  logic                  ERR_CLR
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  // Tooling tags only; kept referenced so they survive elaboration untouched.
  localparam string unused_domain_tag = DOMAIN;
  localparam int    unused_id_tag     = ID;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]   wr_ptr_reg;
  logic [ADDR_WIDTH:0]   rd_ptr_reg;
  logic                  overflow_reg;
  logic                  underflow_reg;

  logic pop_ok;
  logic push_ok;
  logic overflow_event;
  logic underflow_event;

  // Equal index bits with differing MSBs means the writer has lapped the reader.
  assign EMPTY = (wr_ptr_reg == rd_ptr_reg);
  assign FULL  = (wr_ptr_reg[ADDR_WIDTH] != rd_ptr_reg[ADDR_WIDTH]) &&
                 (wr_ptr_reg[ADDR_WIDTH-1:0] == rd_ptr_reg[ADDR_WIDTH-1:0]);
  assign COUNT = wr_ptr_reg - rd_ptr_reg;

  assign pop_ok          = syrup_re && !EMPTY;
  assign push_ok         = syrup_we && (!FULL || pop_ok);
  assign overflow_event  = syrup_we && FULL && !pop_ok;
  assign underflow_event = syrup_re && EMPTY;

  assign syrup_q   = EMPTY ? '0 : mem[rd_ptr_reg[ADDR_WIDTH-1:0]];
  assign OVERFLOW  = overflow_reg;
  assign UNDERFLOW = underflow_reg;

  always_ff @(posedge CLK) begin
    if (push_ok) begin
      mem[wr_ptr_reg[ADDR_WIDTH-1:0]] <= syrup_d;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      // A fresh error in the clearing cycle must not be lost, so set beats clear.
      if (overflow_event) begin
        overflow_reg <= 1'b1;
      end else if (ERR_CLR) begin
        overflow_reg <= 1'b0;
      end
      if (underflow_event) begin
        underflow_reg <= 1'b1;
      end else if (ERR_CLR) begin
        underflow_reg <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_syrup_channel_fifo.sv
// Self-checking bench for syrup_channel_fifo: directed scenarios plus random traffic,
// compared against a queue-based model of the channel rules.
module tb_syrup_channel_fifo;

  localparam int DW    = 32;
  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] syrup_d;
  logic          syrup_we;
  logic [DW-1:0] syrup_q;
  logic          syrup_re;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          underflow;
  logic          err_clr;

  syrup_channel_fifo #(
    .DOMAIN     ("sim"),
    .ID         (3),
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) dut (
    .CLK       (clk),
    .RST       (rst),
    .syrup_d   (syrup_d),
    .syrup_we  (syrup_we),
    .syrup_q   (syrup_q),
    .syrup_re  (syrup_re),
    .FULL      (full),
    .EMPTY     (empty),
    .COUNT     (count),
    .OVERFLOW  (overflow),
    .UNDERFLOW (underflow),
    .ERR_CLR   (err_clr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [DW-1:0] model_q [$];
  bit            model_ovf;
  bit            model_udf;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic check_all(input string ctx);
    logic [63:0] exp_q;
    exp_q = (model_q.size() == 0) ? 64'd0 : 64'(model_q[0]);
    check({ctx, ".count"},     64'(count),     64'(model_q.size()));
    check({ctx, ".empty"},     64'(empty),     64'(model_q.size() == 0));
    check({ctx, ".full"},      64'(full),      64'(model_q.size() == DEPTH));
    check({ctx, ".q"},         64'(syrup_q),   exp_q);
    check({ctx, ".overflow"},  64'(overflow),  64'(model_ovf));
    check({ctx, ".underflow"}, 64'(underflow), 64'(model_udf));
  endtask

  // One clock transaction: drive on the falling edge, apply the channel rules at the
  // rising edge, compare just after it.
  task automatic step(input string ctx, input logic we, input logic [DW-1:0] d,
                      input logic re, input logic clr);
    bit was_full, was_empty, pop, push;
    @(negedge clk);
    syrup_we = we;
    syrup_d  = d;
    syrup_re = re;
    err_clr  = clr;
    @(posedge clk);
    was_full  = (model_q.size() == DEPTH);
    was_empty = (model_q.size() == 0);
    pop  = re && !was_empty;
    push = we && (!was_full || pop);
    if (pop)  void'(model_q.pop_front());
    if (push) model_q.push_back(d);
    if (clr) begin
      model_ovf = 1'b0;
      model_udf = 1'b0;
    end
    if (we && was_full && !pop) model_ovf = 1'b1;
    if (re && was_empty)        model_udf = 1'b1;
    #1;
    $display("%s: we=%0b d=0x%0h re=%0b clr=%0b -> count=%0d q=0x%0h", ctx, we, d, re, clr, count, syrup_q);
    check_all(ctx);
  endtask

  task automatic async_reset(input string ctx);
    @(negedge clk);
    syrup_we = 1'b0;
    syrup_re = 1'b0;
    err_clr  = 1'b0;
    #2 rst = 1'b1;
    #1;
    model_q.delete();
    model_ovf = 1'b0;
    model_udf = 1'b0;
    $display("%s: async reset -> count=%0d q=0x%0h", ctx, count, syrup_q);
    check_all(ctx);
    #1 rst = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    syrup_d  = '0;
    syrup_we = 1'b0;
    syrup_re = 1'b0;
    err_clr  = 1'b0;
    model_ovf = 1'b0;
    model_udf = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_all("reset");
    step("idle", 1'b0, '0, 1'b0, 1'b0);

    // Fill, overflow, drain.
    for (int i = 0; i < 4; i++) step("fill", 1'b1, 32'hA0 + 32'(i), 1'b0, 1'b0);
    check("fill_full", 64'(full), 64'd1);
    check("fill_head", 64'(syrup_q), 64'hA0);
    step("ovf_write", 1'b1, 32'hA4, 1'b0, 1'b0);
    check("ovf_flag", 64'(overflow), 64'd1);
    check("ovf_count", 64'(count), 64'd4);
    for (int i = 0; i < 4; i++) step("drain", 1'b0, '0, 1'b1, 1'b0);
    check("drain_empty", 64'(empty), 64'd1);
    step("clr_ovf", 1'b0, '0, 1'b0, 1'b1);

    // Simultaneous write and pop while full.
    for (int i = 0; i < 4; i++) step("refill", 1'b1, 32'hA0 + 32'(i), 1'b0, 1'b0);
    step("full_wr_rd", 1'b1, 32'hB0, 1'b1, 1'b0);
    check("full_wr_rd_count", 64'(count), 64'd4);
    check("full_wr_rd_ovf", 64'(overflow), 64'd0);
    check("full_wr_rd_head", 64'(syrup_q), 64'hA1);
    for (int i = 0; i < 4; i++) step("drain2", 1'b0, '0, 1'b1, 1'b0);

    // Pop while empty with a write.
    step("udf_write", 1'b1, 32'h55, 1'b1, 1'b0);
    check("udf_flag", 64'(underflow), 64'd1);
    check("udf_head", 64'(syrup_q), 64'h55);
    step("clr_udf", 1'b0, '0, 1'b0, 1'b1);
    check("udf_cleared", 64'(underflow), 64'd0);
    step("pop55", 1'b0, '0, 1'b1, 1'b0);

    // Streaming across several pointer wraps.
    step("stream0", 1'b1, 32'd0, 1'b0, 1'b0);
    for (int i = 1; i < 20; i++) begin
      step("stream", 1'b1, 32'(i), 1'b1, 1'b0);
      check("stream_count", 64'(count), 64'd1);
      check("stream_head", 64'(syrup_q), 64'(i));
    end
    step("stream_last", 1'b0, '0, 1'b1, 1'b0);

    // Asynchronous reset with buffered data.
    for (int i = 0; i < 3; i++) step("pre_rst", 1'b1, 32'hC0 + 32'(i), 1'b0, 1'b0);
    async_reset("rst_mid");
    check("rst_mid_empty", 64'(empty), 64'd1);
    step("post_rst", 1'b1, 32'h77, 1'b0, 1'b0);
    check("post_rst_head", 64'(syrup_q), 64'h77);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      if (i % 97 == 50) async_reset("rand_rst");
      else step("rand", ($urandom_range(0, 99) < 60), $urandom,
                ($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 5));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
